// File: rtl/vx_reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard slice.
//
// Contents:
//   - Default configuration constants (regs per warp, warps per slot, payload and counter widths).
//   - log2up(): ceil(log2(n)) clamped to at least 1 bit, so a one-warp slot still gets an index.
//   - sb_entry_t: the scoreboard-relevant fields of an instruction for the default configuration,
//     packed in the same order the top module uses under its payload.

package vx_reg_scoreboard_pkg;

  localparam int unsigned DEF_NUM_REGS      = 64;
  localparam int unsigned DEF_ISSUE_RATIO   = 4;
  localparam int unsigned DEF_PAYLOADW      = 128;
  localparam int unsigned DEF_PERF_CTR_BITS = 44;

  function automatic int unsigned log2up(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_NR_W  = $clog2(DEF_NUM_REGS);
  localparam int unsigned DEF_WIS_W = log2up(DEF_ISSUE_RATIO);

  typedef struct packed {
    logic [DEF_WIS_W-1:0] wis;
    logic                 wb;
    logic [DEF_NR_W-1:0]  rd;
    logic [DEF_NR_W-1:0]  rs1;
    logic [DEF_NR_W-1:0]  rs2;
    logic [DEF_NR_W-1:0]  rs3;
  } sb_entry_t;

endpackage

// File: rtl/vx_reg_scoreboard_elastic_buffer.sv
// Small elastic FIFO used as the scoreboard's output stage.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset (empties the buffer)
//   push            write push_data this cycle (ignored when full)
//   push_data       DATAW-bit entry
//   full            SIZE entries held; depends only on state, never on pop_ready
//   pop_ready       consumer accepts the head entry
//   pop_valid       head entry valid
//   pop_data        head entry, held stable until accepted
//
// A pushed entry becomes visible at the head one cycle later.

module vx_reg_scoreboard_elastic_buffer #(
  parameter int unsigned SIZE  = 2,
  parameter int unsigned DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  output logic             full,
  input  logic             pop_ready,
  output logic             pop_valid,
  output logic [DATAW-1:0] pop_data
);

  localparam int unsigned PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned CNT_W = $clog2(SIZE + 1);

  logic [DATAW-1:0] mem_q [SIZE];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;

  logic do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (count_q == CNT_W'(SIZE));
  assign pop_valid = (count_q != '0);
  assign pop_data  = mem_q[rptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop_valid && pop_ready;

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= ptr_inc(wptr_q);
      end
      if (do_pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vx_reg_scoreboard.sv
// Per-issue-slot register hazard gate in front of operand collect.
//
// Tracks which destination registers of each warp in this slot still have a write in flight and
// holds back any instruction whose rd (when it writes) or rs1/rs2/rs3 is pending. Released
// instructions pass through a 2-entry elastic buffer to operand collect.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid / in_ready        instruction handshake from the instruction buffer
//   in_wis                     warp index within the slot
//   in_wb, in_rd               instruction writes rd
//   in_rs1, in_rs2, in_rs3     source registers
//   in_payload                 opaque fields forwarded untouched
//   wb_valid, wb_wis, wb_rd    writeback beat (always accepted)
//   wb_eop                     last beat of the writeback; only this beat frees rd
//   out_valid / out_ready      handshake to operand collect
//   out_data                   {payload, wis, wb, rd, rs1, rs2, rs3}
//   perf_stalls                count of cycles with in_valid and a hazard (wraps)

module vx_reg_scoreboard
  import vx_reg_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS      = DEF_NUM_REGS,
  parameter int unsigned ISSUE_RATIO   = DEF_ISSUE_RATIO,
  parameter int unsigned PAYLOADW      = DEF_PAYLOADW,
  parameter int unsigned PERF_CTR_BITS = DEF_PERF_CTR_BITS,
  localparam int unsigned NR_W         = $clog2(NUM_REGS),
  localparam int unsigned WIS_W        = log2up(ISSUE_RATIO),
  localparam int unsigned OUTW         = PAYLOADW + WIS_W + 1 + 4 * NR_W
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIS_W-1:0]         in_wis,
  input  logic                     in_wb,
  input  logic [NR_W-1:0]          in_rd,
  input  logic [NR_W-1:0]          in_rs1,
  input  logic [NR_W-1:0]          in_rs2,
  input  logic [NR_W-1:0]          in_rs3,
  input  logic [PAYLOADW-1:0]      in_payload,

  input  logic                     wb_valid,
  input  logic [WIS_W-1:0]         wb_wis,
  input  logic [NR_W-1:0]          wb_rd,
  input  logic                     wb_eop,

  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUTW-1:0]          out_data,

  output logic [PERF_CTR_BITS-1:0] perf_stalls
);

  typedef logic [ISSUE_RATIO-1:0][NUM_REGS-1:0] pend_t;

  pend_t pending_q, pending_d;
  pend_t release_mask;
  pend_t pend_eff;

  logic [PERF_CTR_BITS-1:0] perf_q;

  logic              wb_release;
  logic              hazard;
  logic              buf_full;
  logic              fire;
  logic              set_en;
  logic [OUTW-1:0]   in_entry;

  // Release decode: only the final beat of a writeback frees the register.
  assign wb_release = wb_valid && wb_eop;

  always_comb begin
    release_mask = '0;
    if (wb_release) begin
      release_mask[wb_wis][wb_rd] = 1'b1;
    end
  end

  // Bypassed view so an instruction waiting on a register can go in the same cycle it is freed.
  assign pend_eff = pending_q & ~release_mask;

  // rd is checked too (WAW) but only when the instruction actually writes it.
  assign hazard = (in_wb && pend_eff[in_wis][in_rd])
                | pend_eff[in_wis][in_rs1]
                | pend_eff[in_wis][in_rs2]
                | pend_eff[in_wis][in_rs3];

  // Deliberately independent of out_ready: buf_full is pure state.
  assign in_ready = !reset && !buf_full && !hazard;
  assign fire     = in_valid && in_ready;
  assign set_en   = fire && in_wb && (in_rd != '0);

  // The set is applied after the clear, so a new owner of a register wins over a stale release.
  // Register 0 is never marked pending.
  always_comb begin
    pending_d = pend_eff;
    if (set_en) begin
      pending_d[in_wis][in_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if (in_valid && hazard) begin
      perf_q <= perf_q + PERF_CTR_BITS'(1);
    end
  end

  assign perf_stalls = perf_q;

  assign in_entry = {in_payload, in_wis, in_wb, in_rd, in_rs1, in_rs2, in_rs3};

  vx_reg_scoreboard_elastic_buffer #(
    .SIZE  (2),
    .DATAW (OUTW)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (fire),
    .push_data (in_entry),
    .full      (buf_full),
    .pop_ready (out_ready),
    .pop_valid (out_valid),
    .pop_data  (out_data)
  );

endmodule

// File: tb/tb_vx_reg_scoreboard.sv
module tb_vx_reg_scoreboard;
  import vx_reg_scoreboard_pkg::*;

  localparam int NR = 64;
  localparam int IR = 4;
  localparam int PW = 128;
  localparam int PB = 44;
  localparam int NW = $clog2(NR);
  localparam int WW = log2up(IR);
  localparam int DW = PW + WW + 1 + 4 * NW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_wb;
  logic [WW-1:0] in_wis;
  logic [NW-1:0] in_rd, in_rs1, in_rs2, in_rs3;
  logic [PW-1:0] in_payload;
  logic          wb_valid, wb_eop;
  logic [WW-1:0] wb_wis;
  logic [NW-1:0] wb_rd;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [PB-1:0] perf_stalls;

  vx_reg_scoreboard #(
    .NUM_REGS      (NR),
    .ISSUE_RATIO   (IR),
    .PAYLOADW      (PW),
    .PERF_CTR_BITS (PB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_wis      (in_wis),
    .in_wb       (in_wb),
    .in_rd       (in_rd),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_rs3      (in_rs3),
    .in_payload  (in_payload),
    .wb_valid    (wb_valid),
    .wb_wis      (wb_wis),
    .wb_rd       (wb_rd),
    .wb_eop      (wb_eop),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .perf_stalls (perf_stalls)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: per-warp set of registers with an outstanding write, the expected output
  // stream in order, and the expected stall count.
  bit              pend [IR][NR];
  logic [DW-1:0]   expq [$];
  longint unsigned exp_stalls = 0;
  bit              popped = 0;
  bit              mon_en = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the head of the expected stream.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      popped = 0;
      if (mon_en) begin
        chk("out_valid", 256'(out_valid), 256'(expq.size() != 0));
        if (out_valid && expq.size() != 0) begin
          chk("out_data", 256'(out_data), 256'(expq[0]));
          if (out_ready) begin
            void'(expq.pop_front());
            popped = 1;
          end
        end
      end
    end
  end

  function automatic bit model_hazard();
    bit busy [NR];
    for (int r = 0; r < NR; r++) busy[r] = pend[in_wis][r];
    if (wb_valid && wb_eop && wb_wis == in_wis) busy[wb_rd] = 0;
    return (in_wb && busy[in_rd]) || busy[in_rs1] || busy[in_rs2] || busy[in_rs3];
  endfunction

  // Per-cycle check and model update; inputs for this cycle are already applied.
  task automatic cycle_check();
    int        occ;
    bit        haz, exp_rdy;
    sb_entry_t e;
    #2;
    occ     = expq.size() + (popped ? 1 : 0);
    haz     = model_hazard();
    exp_rdy = !reset && occ < 2 && !haz;
    chk("in_ready", 256'(in_ready), 256'(exp_rdy));
    chk("perf_stalls", 256'(perf_stalls), 256'(exp_stalls[PB-1:0]));
    if (reset) begin
      expq.delete();
      for (int w = 0; w < IR; w++) for (int r = 0; r < NR; r++) pend[w][r] = 0;
      exp_stalls = 0;
    end else begin
      if (in_valid && haz) exp_stalls++;
      if (wb_valid && wb_eop) pend[wb_wis][wb_rd] = 0;
      if (in_valid && exp_rdy) begin
        e.wis = in_wis; e.wb = in_wb; e.rd = in_rd;
        e.rs1 = in_rs1; e.rs2 = in_rs2; e.rs3 = in_rs3;
        expq.push_back({in_payload, e});
        if (in_wb && in_rd != 0) pend[in_wis][in_rd] = 1;
      end
    end
  endtask

  task automatic idle();
    reset = 0; in_valid = 0; in_wis = '0; in_wb = 0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0;
    in_payload = {$urandom, $urandom, $urandom, $urandom};
    wb_valid = 0; wb_wis = '0; wb_rd = '0; wb_eop = 0;
    out_ready = 1;
  endtask

  task automatic set_in(input int w, input bit wb, input int rd, input int r1, input int r2,
                        input int r3);
    in_valid = 1; in_wis = WW'(w); in_wb = wb;
    in_rd = NW'(rd); in_rs1 = NW'(r1); in_rs2 = NW'(r2); in_rs3 = NW'(r3);
  endtask

  task automatic set_wb(input int w, input int rd, input bit eop);
    wb_valid = 1; wb_wis = WW'(w); wb_rd = NW'(rd); wb_eop = eop;
  endtask

  function automatic logic [NW-1:0] rand_reg();
    return ($urandom_range(3) == 0) ? NW'($urandom_range(NR - 1)) : NW'($urandom_range(7));
  endfunction

  task automatic rand_inputs();
    reset      = ($urandom_range(299) == 0);
    in_valid   = ($urandom_range(9) < 8);
    in_wis     = WW'($urandom_range(IR - 1));
    in_wb      = 1'($urandom_range(1));
    in_rd      = rand_reg();
    in_rs1     = rand_reg();
    in_rs2     = rand_reg();
    in_rs3     = rand_reg();
    in_payload = {$urandom, $urandom, $urandom, $urandom};
    wb_valid   = 1'($urandom_range(1));
    wb_wis     = WW'($urandom_range(IR - 1));
    wb_rd      = NW'($urandom_range(7));
    wb_eop     = ($urandom_range(4) != 0);
    out_ready  = ($urandom_range(9) < 7);
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    mon_en = 1;

    // Reset state.
    @(negedge clk); idle(); reset = 1; cycle_check();
    @(negedge clk); idle(); cycle_check();

    // Fire wis0 rd5, then rs1=5 stalls until the eop beat frees it.
    @(negedge clk); idle(); set_in(0, 1, 5, 1, 2, 3); cycle_check();
    repeat (3) begin @(negedge clk); idle(); set_in(0, 0, 0, 5, 0, 0); cycle_check(); end
    @(negedge clk); idle(); set_in(0, 0, 0, 5, 0, 0); set_wb(0, 5, 0); cycle_check();
    @(negedge clk); idle(); set_in(0, 0, 0, 5, 0, 0); set_wb(0, 5, 1); cycle_check();

    // Warp isolation.
    @(negedge clk); idle(); set_in(0, 1, 5, 0, 0, 0); cycle_check();
    @(negedge clk); idle(); set_in(1, 0, 0, 5, 5, 5); cycle_check();

    // rd=0 never becomes pending.
    @(negedge clk); idle(); set_in(1, 1, 0, 0, 0, 0); cycle_check();
    @(negedge clk); idle(); set_in(1, 1, 0, 0, 0, 0); cycle_check();

    // Backpressure: two accepted, then full; drain in order.
    repeat (4) begin
      @(negedge clk); idle(); out_ready = 0; set_in(3, 0, 0, 0, 0, 0); cycle_check();
    end
    repeat (3) begin @(negedge clk); idle(); cycle_check(); end

    // Same-cycle set and stale release of the same reg: set wins; then reset mid-operation.
    @(negedge clk); idle(); set_in(2, 1, 7, 0, 0, 0); set_wb(2, 7, 1); cycle_check();
    @(negedge clk); idle(); set_in(2, 0, 0, 7, 0, 0); cycle_check();
    @(negedge clk); idle(); out_ready = 0; set_in(2, 0, 0, 7, 0, 0); reset = 1; cycle_check();
    @(negedge clk); idle(); set_in(2, 0, 0, 7, 0, 0); cycle_check();

    // Randomized traffic.
    repeat (3000) begin @(negedge clk); rand_inputs(); cycle_check(); end

    repeat (4) begin @(negedge clk); idle(); cycle_check(); end
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
